// File: rtl/reaction_timer_bcd.sv
// Reaction-time stopwatch: ms prescaler feeding an N-digit BCD counter, with
// saturating timeout, best-time tracking and a registered seven-segment display.

module reaction_timer_bcd_seg (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    // {g,f,e,d,c,b,a}, active low
    always_comb begin
        seg = 7'b1111111;
        if (dash) begin
            seg = 7'b0111111;
        end else if (!blank) begin
            case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end
endmodule

module reaction_timer_bcd #(
    parameter int CLKS_PER_MS = 50000,
    parameter int NUM_DIGITS  = 3,
    parameter int TIMEOUT_MS  = 999
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_evt,
    input  logic                    stop_evt,
    input  logic                    clear_best,
    input  logic                    show_best,
    output logic                    running,
    output logic                    timeout,
    output logic                    new_best,
    output logic [4*NUM_DIGITS-1:0] last_bcd,
    output logic [4*NUM_DIGITS-1:0] best_bcd,
    output logic [7*NUM_DIGITS-1:0] seg
);
    localparam int PW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    function automatic logic [DW-1:0] to_bcd(input int v);
        logic [DW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [DW-1:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);
    localparam logic [DW-1:0] ALL_NINES   = {NUM_DIGITS{4'h9}};

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [DW-1:0] count, count_inc, count_nxt;
    logic          carry;
    logic          wrap;
    logic          upd_pend;
    logic          best_valid;

    assign running   = (state == S_RUN);
    assign wrap      = (presc == PW'(CLKS_PER_MS - 1));
    assign count_nxt = wrap ? count_inc : count;

    // Decimal ripple-carry increment, ones digit first.
    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count[4*i+:4] == 4'd9) begin
                    count_inc[4*i+:4] = 4'd0;
                end else begin
                    count_inc[4*i+:4] = count[4*i+:4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Stop beats restart; restart beats the timeout check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            count    <= '0;
            last_bcd <= '0;
            timeout  <= 1'b0;
            upd_pend <= 1'b0;
        end else begin
            upd_pend <= 1'b0;
            case (state)
                S_IDLE, S_HOLD: begin
                    if (start_evt) begin
                        presc   <= '0;
                        count   <= '0;
                        timeout <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop_evt) begin
                        last_bcd <= count_nxt;
                        upd_pend <= 1'b1;
                        state    <= S_HOLD;
                    end else if (start_evt) begin
                        presc <= '0;
                        count <= '0;
                    end else if (wrap && count_inc == TIMEOUT_BCD) begin
                        last_bcd <= TIMEOUT_BCD;
                        timeout  <= 1'b1;
                        state    <= S_HOLD;
                    end else begin
                        presc <= wrap ? '0 : presc + PW'(1);
                        count <= count_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Best compare runs one cycle after the stop, against the freshly held last.
    // Valid BCD digits make an unsigned compare equal to an MSD-first compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_bcd   <= ALL_NINES;
            best_valid <= 1'b0;
            new_best   <= 1'b0;
        end else begin
            new_best <= 1'b0;
            if (upd_pend && (!best_valid || last_bcd < best_bcd)) begin
                best_bcd   <= last_bcd;
                best_valid <= 1'b1;
                new_best   <= 1'b1;
            end else if (clear_best) begin
                best_bcd   <= ALL_NINES;
                best_valid <= 1'b0;
            end
        end
    end

    logic [DW-1:0]           src;
    logic                    dash;
    logic [NUM_DIGITS-1:0]   blank;
    logic [7*NUM_DIGITS-1:0] seg_nxt;

    assign src  = show_best ? best_bcd : last_bcd;
    assign dash = show_best && !best_valid;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_ones
            assign blank[i] = 1'b0;
        end else begin : g_upper
            assign blank[i] = ~|src[DW-1:4*i];
        end
        reaction_timer_bcd_seg u_seg (
            .digit(src[4*i+:4]),
            .blank(blank[i]),
            .dash (dash),
            .seg  (seg_nxt[7*i+:7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg      <= '1;
            seg[6:0] <= 7'b1000000;
        end else begin
            seg <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Scoreboard bench for reaction_timer_bcd at CLKS_PER_MS=5, NUM_DIGITS=3, TIMEOUT_MS=50.
module tb_reaction_timer_bcd;
    localparam int C   = 5;
    localparam int ND  = 3;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst, start_evt, stop_evt, clear_best, show_best;
    logic running, timeout, new_best;
    logic [4*ND-1:0] last_bcd, best_bcd;
    logic [7*ND-1:0] seg;

    reaction_timer_bcd #(.CLKS_PER_MS(C), .NUM_DIGITS(ND), .TIMEOUT_MS(TMO)) dut (
        .clk(clk), .rst(rst), .start_evt(start_evt), .stop_evt(stop_evt),
        .clear_best(clear_best), .show_best(show_best), .running(running),
        .timeout(timeout), .new_best(new_best), .last_bcd(last_bcd),
        .best_bcd(best_bcd), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] last;
        logic [11:0] best;
        logic        nb;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] model_best  = 12'h999;
    bit          model_valid = 1'b0;

    localparam logic [20:0] SEG_RST  = {7'b1111111, 7'b1111111, 7'b1000000};
    localparam logic [20:0] SEG_DASH = {3{7'b0111111}};

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected outcome of a stop after s cycles, pushed as the stop is driven.
    task automatic push_stop(input int s);
        exp_t e;
        e.last = bcd(s / C);
        e.nb   = !model_valid || (s / C) < (model_best[11:8] * 100 + model_best[7:4] * 10 + model_best[3:0]);
        if (e.nb) begin
            model_best  = e.last;
            model_valid = 1'b1;
        end
        e.best = model_best;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1; start_evt = 1'b0; stop_evt = 1'b0; clear_best = 1'b0; show_best = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        n_tests++; if (seg !== SEG_RST) begin n_fail++; $display("FAIL reset_seg: got %b want %b", seg, SEG_RST); end
        n_tests++; if (running !== 1'b0 || timeout !== 1'b0 || new_best !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got r=%b t=%b nb=%b want 000", running, timeout, new_best); end
        n_tests++; if (last_bcd !== 12'h000 || best_bcd !== 12'h999) begin
            n_fail++; $display("FAIL reset_vals: got last=%h best=%h want 000/999", last_bcd, best_bcd); end
        show_best = 1'b1;
        tick(1);
        n_tests++; if (seg !== SEG_DASH) begin n_fail++; $display("FAIL reset_dash: got %b want %b", seg, SEG_DASH); end
        show_best = 1'b0;
        tick(1);
    endtask

    task automatic test_single;
        exp_t e;
        start_evt = 1'b1; tick(1); start_evt = 1'b0;
        tick(184);
        stop_evt = 1'b1; push_stop(185); tick(1); stop_evt = 1'b0;
        e = sb.pop_front();
        n_tests++; if (last_bcd !== e.last) begin n_fail++; $display("FAIL single_last: got %h want %h", last_bcd, e.last); end
        tick(1);
        n_tests++; if (new_best !== e.nb || best_bcd !== e.best) begin
            n_fail++; $display("FAIL single_best: got nb=%b best=%h want nb=%b best=%h", new_best, best_bcd, e.nb, e.best); end
        n_tests++; if (seg !== {7'b1111111, 7'b0110000, 7'b1111000}) begin
            n_fail++; $display("FAIL single_seg: got %b want 111111101100001111000", seg); end
        tick(1);
        n_tests++; if (new_best !== 1'b0) begin n_fail++; $display("FAIL single_nb_pulse: got %b want 0", new_best); end
    endtask

    task automatic test_best_tracking;
        int lens[2] = '{40, 100};
        exp_t e;
        foreach (lens[k]) begin
            start_evt = 1'b1; tick(1); start_evt = 1'b0;
            tick(lens[k] - 1);
            stop_evt = 1'b1; push_stop(lens[k]); tick(1); stop_evt = 1'b0;
            e = sb.pop_front();
            n_tests++; if (last_bcd !== e.last || running !== 1'b0) begin
                n_fail++; $display("FAIL best_last[%0d]: got %h r=%b want %h r=0", k, last_bcd, running, e.last); end
            tick(1);
            n_tests++; if (new_best !== e.nb || best_bcd !== e.best) begin
                n_fail++; $display("FAIL best_upd[%0d]: got nb=%b best=%h want nb=%b best=%h", k, new_best, best_bcd, e.nb, e.best); end
            tick(2);
        end
    endtask

    task automatic test_timeout;
        int cnt = 0;
        start_evt = 1'b1; tick(1); start_evt = 1'b0;
        while (running && cnt < 300) begin tick(1); cnt++; end
        n_tests++; if (cnt !== TMO * C) begin n_fail++; $display("FAIL tmo_cycles: got %0d want %0d", cnt, TMO * C); end
        n_tests++; if (timeout !== 1'b1 || last_bcd !== bcd(TMO)) begin
            n_fail++; $display("FAIL tmo_vals: got t=%b last=%h want 1/%h", timeout, last_bcd, bcd(TMO)); end
        tick(1);
        n_tests++; if (new_best !== 1'b0 || best_bcd !== model_best) begin
            n_fail++; $display("FAIL tmo_best: got nb=%b best=%h want 0/%h", new_best, best_bcd, model_best); end
        start_evt = 1'b1; tick(1); start_evt = 1'b0;
        n_tests++; if (timeout !== 1'b0 || running !== 1'b1) begin
            n_fail++; $display("FAIL tmo_clear: got t=%b r=%b want 0/1", timeout, running); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        start_evt = 1'b1; tick(1); start_evt = 1'b0;
        tick(29);
        start_evt = 1'b1; tick(1); start_evt = 1'b0;
        tick(59);
        stop_evt = 1'b1; push_stop(60); tick(1); stop_evt = 1'b0;
        e = sb.pop_front();
        n_tests++; if (last_bcd !== e.last) begin n_fail++; $display("FAIL restart_last: got %h want %h", last_bcd, e.last); end
        tick(1);
        n_tests++; if (new_best !== e.nb || best_bcd !== e.best) begin
            n_fail++; $display("FAIL restart_best: got nb=%b best=%h want nb=%b best=%h", new_best, best_bcd, e.nb, e.best); end
        start_evt = 1'b1; tick(1); start_evt = 1'b0;
        tick(19);
        start_evt = 1'b1; stop_evt = 1'b1; push_stop(20); tick(1); start_evt = 1'b0; stop_evt = 1'b0;
        e = sb.pop_front();
        n_tests++; if (last_bcd !== e.last || running !== 1'b0) begin
            n_fail++; $display("FAIL both_last: got %h r=%b want %h r=0", last_bcd, running, e.last); end
        tick(1);
        n_tests++; if (new_best !== e.nb || best_bcd !== e.best || running !== 1'b0) begin
            n_fail++; $display("FAIL both_best: got nb=%b best=%h r=%b want nb=%b best=%h r=0", new_best, best_bcd, running, e.nb, e.best); end
    endtask

    task automatic test_clear_and_reset;
        show_best = 1'b1; clear_best = 1'b1; tick(1); clear_best = 1'b0;
        model_valid = 1'b0; model_best = 12'h999;
        n_tests++; if (best_bcd !== model_best) begin n_fail++; $display("FAIL clear_best: got %h want %h", best_bcd, model_best); end
        tick(1);
        n_tests++; if (seg !== SEG_DASH) begin n_fail++; $display("FAIL clear_dash: got %b want %b", seg, SEG_DASH); end
        show_best = 1'b0;
        start_evt = 1'b1; tick(1); start_evt = 1'b0;
        tick(20);
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL rst_pre_run: got %b want 1", running); end
        rst = 1'b1; #1;
        n_tests++; if (running !== 1'b0 || last_bcd !== 12'h000 || best_bcd !== 12'h999 || seg !== SEG_RST) begin
            n_fail++; $display("FAIL rst_mid_run: got r=%b last=%h best=%h seg=%b", running, last_bcd, best_bcd, seg); end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset;
        test_single;
        test_best_tracking;
        test_timeout;
        test_back_to_back;
        test_clear_and_reset;
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/reaction_timer_bcd.md
Name: reaction_timer_bcd

Overview:
- Parametrised successor to the two-digit reaction-time display used in Whac-A-Mole.
- Measures start-to-stop interval in milliseconds with an N-digit BCD counter.
- Adds saturating timeout, best (minimum) time tracking and a last/best display mode.
- Drives N common-anode seven-segment digits with leading-zero blanking; sits between game FSM event pulses and the HEX outputs.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick; must be >= 2.
- NUM_DIGITS, 3, number of BCD digits and seven-segment outputs; must be 1..6.
- TIMEOUT_MS, 999, automatic stop value; must be <= 10^NUM_DIGITS - 1.

Ports:
- clk  in  1  system clock, single clock domain, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_evt  in  1  one-cycle pulse: mole appears, begin timing.
- stop_evt  in  1  one-cycle pulse: correct hit, end timing.
- clear_best  in  1  one-cycle pulse: invalidate best time.
- show_best  in  1  level: 1 = display best, 0 = display last.
- running  out  1  high while in RUN.
- timeout  out  1  high in HOLD when the last measurement timed out.
- new_best  out  1  one-cycle pulse when best is updated.
- last_bcd  out  4*NUM_DIGITS  last measured time, BCD, digit 0 = ones in [3:0].
- best_bcd  out  4*NUM_DIGITS  best time, BCD; all 9s when invalid.
- seg  out  7*NUM_DIGITS  per digit {g,f,e,d,c,b,a}, 0 = segment on; digit 0 in [6:0].

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; prescaler=0; counter=0.
  - last_bcd=0; best_bcd=all 9s; best_valid=0.
  - running=0, timeout=0, new_best=0.
  - seg=ones "0" (1000000), other digits blank (1111111).
- States: IDLE, RUN, HOLD.
- IDLE/HOLD:
  - start_evt clears prescaler and counter, clears timeout, enters RUN.
  - stop_evt is ignored.
- RUN, prescaler:
  - Increments every cycle; wraps CLKS_PER_MS-1 -> 0.
  - On wrap, the BCD counter increments with per-digit ripple carry (9 -> 0, carry into next digit).
- RUN, stop_evt at edge E:
  - last_bcd <= counter value including any increment occurring at the same edge. Result = floor(S/CLKS_PER_MS), where S is the number of cycles from start edge to stop edge.
  - Enter HOLD.
- RUN, timeout: when the counter value would become TIMEOUT_MS and no stop_evt is present:
  - last_bcd <= TIMEOUT_MS; timeout <= 1; enter HOLD.
  - best is not updated.
- RUN, start_evt without stop_evt: restart; prescaler and counter cleared, stay in RUN.
- RUN, start_evt and stop_evt in the same cycle: stop wins, start ignored.
- Best update (non-timeout stop): if best_valid=0 or last < best (BCD compare, MSD first):
  - best_bcd <= last; best_valid <= 1; new_best pulses 1 cycle later (aligned with best_bcd update).
- clear_best: best_valid <= 0; best_bcd <= all 9s. If coincident with a best update, the update wins.
- Display:
  - Source digits = best_bcd if show_best else last_bcd.
  - show_best=1 and best_valid=0: every digit shows dash (0111111).
  - Otherwise, leading-zero blanking on all digits except digit 0.
  - seg is registered, 1-cycle latency from source change. Stop at edge E gives last_bcd valid after E and seg valid after E+1.
- Display during RUN shows the held last/best values, not the live counter.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-RUN: immediate return to reset values, including best.

Test Plan:
Bench configuration: CLKS_PER_MS=5, NUM_DIGITS=3, TIMEOUT_MS=50.
1. Reset, show_best=0 -> seg = {1111111,1111111,1000000}; show_best=1 -> all three digits 0111111; running=0.
2. start_evt, stop_evt 185 cycles later -> last_bcd=0x037, new_best pulse, best_bcd=0x037; seg = {blank,0110000,1111000}.
3. start_evt, stop after 40 cycles -> last=0x008, new_best, best=0x008; then stop after 100 cycles -> last=0x020, no new_best, best stays 0x008.
4. start_evt, no stop -> 250 cycles later running=0, timeout=1, last=0x050, best unchanged. A new start clears timeout.
5. In RUN, restart via start_evt at 30 cycles, stop 60 cycles later -> last=0x012. Start+stop in the same cycle at 20 cycles into RUN -> last=0x004, state HOLD.
6. clear_best with show_best=1 -> dashes, best_bcd=0x999. rst asserted mid-RUN -> running=0, last=0, seg back to reset pattern.
